// File: rtl/bitstream_reader_pkg.sv
// Shared widths for the variable-length bit packer/unpacker pair.
// Also carries the low-bit mask helper used to keep unread-buffer tails clean.
package bitstream_reader_pkg;

   localparam int WORD_W = 32;
   localparam int BUF_W  = 64;
   localparam int CNT_W  = 7;
   localparam int LEN_W  = 6;

   typedef logic [BUF_W-1:0]  buf_t;
   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [LEN_W-1:0]  len_t;
   typedef logic [WORD_W-1:0] word_t;

   localparam cnt_t WORD_CNT = CNT_W'(WORD_W);
   localparam cnt_t BUF_CNT  = CNT_W'(BUF_W);

   // Ones in bits [n-1:0]; n == BUF_W yields all ones.
   function automatic buf_t low_mask(input cnt_t n);
      buf_t m;
      if (n >= BUF_CNT) begin
         m = '1;
      end else begin
         m = (buf_t'(1) << n) - buf_t'(1);
      end
      return m;
   endfunction

endpackage

// File: rtl/bitstream_reader_bit_shifter64.sv
// Combinational 64-bit logical right shift, six log stages (1,2,4,8,16,32).
// Zeros fill from the top.
module bit_shifter64
   import bitstream_reader_pkg::*;
(
   input  logic [BUF_W-1:0] din,
   input  logic [LEN_W-1:0] amt,
   output logic [BUF_W-1:0] dout
);

   logic [BUF_W-1:0] s1, s2, s3, s4, s5;

   assign s1   = amt[0] ? (din >> 1)  : din;
   assign s2   = amt[1] ? (s1  >> 2)  : s1;
   assign s3   = amt[2] ? (s2  >> 4)  : s2;
   assign s4   = amt[3] ? (s3  >> 8)  : s3;
   assign s5   = amt[4] ? (s4  >> 16) : s4;
   assign dout = amt[5] ? (s5  >> 32) : s5;

endmodule

// File: rtl/bitstream_reader.sv
// LSB-first bit unpacker: 32-bit words in, 0..32 bits consumed per cycle, 64-bit buffer.
// Outputs registered (1-cycle latency); iready is a compare on the fill count only.
module bitstream_reader
   import bitstream_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              ivalid,
   output logic              iready,
   input  logic [WORD_W-1:0] idata,
   output logic [WORD_W-1:0] odata,
   output logic [CNT_W-1:0]  oavail,
   output logic [2:0]        opad,
   input  logic [LEN_W-1:0]  consume,
   output logic              err
);

   buf_t       bits_q;
   cnt_t       cnt_q;
   logic [2:0] pos_q;
   logic       err_q;

   cnt_t       need;
   cnt_t       lim;
   cnt_t       take;
   cnt_t       rem;
   cnt_t       cnt_nxt;
   logic       over;
   logic       acc;
   buf_t       shifted;
   buf_t       ins;
   buf_t       bits_nxt;
   logic [2:0] pos_nxt;

   assign iready = (cnt_q <= WORD_CNT);
   assign acc    = ivalid & iready;

   // Effective consume is clamped to what is buffered and to one word.
   always_comb begin
      need = {1'b0, consume};
      lim  = (cnt_q > WORD_CNT) ? WORD_CNT : cnt_q;
      take = (need > lim) ? lim : need;
      over = (need > cnt_q) || (need > WORD_CNT);
      rem  = cnt_q - take;
   end

   bit_shifter64 u_shift (
      .din  (bits_q),
      .amt  (take[LEN_W-1:0]),
      .dout (shifted)
   );

   // New word lands directly above the bits that survive this cycle's consume.
   always_comb begin
      ins      = acc ? (buf_t'(idata) << rem) : '0;
      cnt_nxt  = rem + (acc ? WORD_CNT : '0);
      bits_nxt = (shifted | ins) & low_mask(cnt_nxt);
      pos_nxt  = pos_q + take[2:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         bits_q <= '0;
         cnt_q  <= '0;
         pos_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         bits_q <= bits_nxt;
         cnt_q  <= cnt_nxt;
         pos_q  <= pos_nxt;
         err_q  <= err_q | over;
      end
   end

   assign odata  = bits_q[WORD_W-1:0];
   assign oavail = cnt_q;
   assign opad   = 3'd0 - pos_q;
   assign err    = err_q;

endmodule

// File: tb/tb_bitstream_reader.sv
// Bench for bitstream_reader: directed vector table plus random traffic vs a bit-queue model.
module tb_bitstream_reader;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        ivalid;
   logic        iready;
   logic [31:0] idata;
   logic [31:0] odata;
   logic [6:0]  oavail;
   logic [2:0]  opad;
   logic [5:0]  consume;
   logic        err;

   int checks = 0;
   int errors = 0;

   bitstream_reader dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .ivalid  (ivalid),
      .iready  (iready),
      .idata   (idata),
      .odata   (odata),
      .oavail  (oavail),
      .opad    (opad),
      .consume (consume),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the stream as a queue of unread bits.
   bit mq[$];
   int mpos = 0;
   bit merr = 1'b0;

   typedef struct {
      logic        rn;
      logic        cl;
      logic        iv;
      logic [31:0] id;
      logic [5:0]  cs;
      logic [31:0] eo;
      logic [6:0]  ea;
      logic [2:0]  ep;
      logic        er;
      logic        ee;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_step(input logic rn, input logic cl, input logic iv,
                             input logic [31:0] id, input logic [5:0] cs);
      int sz;
      int c;
      bit take_word;
      if (!rn || cl) begin
         mq.delete();
         mpos = 0;
         merr = 1'b0;
      end else begin
         sz = mq.size();
         take_word = iv && (sz <= 32);
         c = int'(cs);
         if (c > sz || c > 32) merr = 1'b1;
         if (c > sz) c = sz;
         if (c > 32) c = 32;
         repeat (c) void'(mq.pop_front());
         mpos = (mpos + c) % 8;
         if (take_word)
            for (int i = 0; i < 32; i++) mq.push_back(id[i]);
      end
   endtask

   function automatic logic [31:0] model_window();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++)
         if (i < mq.size()) w[i] = mq[i];
      return w;
   endfunction

   // Drive one cycle of inputs at the falling edge, advance, and compare against the model.
   task automatic apply(input logic rn, input logic cl, input logic iv,
                        input logic [31:0] id, input logic [5:0] cs);
      rst_n   = rn;
      clear   = cl;
      ivalid  = iv;
      idata   = id;
      consume = cs;
      model_step(rn, cl, iv, id, cs);
      @(posedge clk);
      @(negedge clk);
      chk("model_odata",  64'(odata),  64'(model_window()));
      chk("model_oavail", 64'(oavail), 64'(mq.size()));
      chk("model_opad",   64'(opad),   64'((8 - mpos) % 8));
      chk("model_iready", 64'(iready), 64'(mq.size() <= 32));
      chk("model_err",    64'(err),    64'(merr));
   endtask

   function automatic vec_t mk(input logic rn, input logic cl, input logic iv,
                               input logic [31:0] id, input logic [5:0] cs,
                               input logic [31:0] eo, input logic [6:0] ea,
                               input logic [2:0] ep, input logic er, input logic ee);
      vec_t v;
      v.rn = rn; v.cl = cl; v.iv = iv; v.id = id; v.cs = cs;
      v.eo = eo; v.ea = ea; v.ep = ep; v.er = er; v.ee = ee;
      return v;
   endfunction

   initial begin
      logic [31:0] w;
      int          r;
      logic        rn, cl, iv;
      logic [5:0]  cs;

      rst_n = 1'b0; clear = 1'b0; ivalid = 1'b0; idata = '0; consume = '0;
      @(negedge clk);

      //           rn cl iv idata         cs   odata         avail opad rdy err
      tbl.push_back(mk(0, 0, 0, 32'h0,        0,  32'h0,        0,  0, 1, 0));
      // reset and fill
      tbl.push_back(mk(1, 0, 1, 32'hDEADBEEF, 0,  32'hDEADBEEF, 32, 0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,        0,  32'h0,        0,  0, 1, 0));
      // straddling fields
      tbl.push_back(mk(1, 0, 1, 32'h0000000F, 0,  32'h0000000F, 32, 0, 1, 0));
      tbl.push_back(mk(1, 0, 1, 32'hFFFFFFF0, 4,  32'h00000000, 60, 4, 0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,        8,  32'hFF000000, 52, 4, 0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,        0,  32'h0,        0,  0, 1, 0));
      // stall at 64, third word held until consume drains to 32
      tbl.push_back(mk(1, 0, 1, 32'hAAAA0001, 0,  32'hAAAA0001, 32, 0, 1, 0));
      tbl.push_back(mk(1, 0, 1, 32'hBBBB0002, 0,  32'hAAAA0001, 64, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 32'hCCCC0003, 0,  32'hAAAA0001, 64, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 32'hCCCC0003, 32, 32'hBBBB0002, 32, 0, 1, 0));
      tbl.push_back(mk(1, 0, 1, 32'hCCCC0003, 0,  32'hBBBB0002, 64, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,        32, 32'hCCCC0003, 32, 0, 1, 0));
      // overrun with 5 bits left
      tbl.push_back(mk(1, 0, 0, 32'h0,        27, 32'h00000019, 5,  5, 1, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,        9,  32'h0,        0,  0, 1, 1));
      tbl.push_back(mk(1, 0, 0, 32'h0,        0,  32'h0,        0,  0, 1, 1));
      tbl.push_back(mk(1, 0, 1, 32'h0F0F0F0F, 0,  32'h0F0F0F0F, 32, 0, 1, 1));
      // clear mid-stream at 40 bits with a word offered
      tbl.push_back(mk(1, 0, 1, 32'h11111111, 0,  32'h0F0F0F0F, 64, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 32'h0,        24, 32'h1111110F, 40, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1, 32'h99999999, 5,  32'h0,        0,  0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,        0,  32'h0,        0,  0, 1, 0));
      // consume above 32 clamps to 32 and flags overrun
      tbl.push_back(mk(1, 0, 1, 32'h87654321, 0,  32'h87654321, 32, 0, 1, 0));
      tbl.push_back(mk(1, 0, 1, 32'h0000FFFF, 0,  32'h87654321, 64, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,        33, 32'h0000FFFF, 32, 0, 1, 1));
      tbl.push_back(mk(1, 1, 0, 32'h0,        0,  32'h0,        0,  0, 1, 0));

      foreach (tbl[k]) begin
         apply(tbl[k].rn, tbl[k].cl, tbl[k].iv, tbl[k].id, tbl[k].cs);
         chk($sformatf("vec%0d_odata", k),  64'(odata),  64'(tbl[k].eo));
         chk($sformatf("vec%0d_oavail", k), 64'(oavail), 64'(tbl[k].ea));
         chk($sformatf("vec%0d_opad", k),   64'(opad),   64'(tbl[k].ep));
         chk($sformatf("vec%0d_iready", k), 64'(iready), 64'(tbl[k].er));
         chk($sformatf("vec%0d_err", k),    64'(err),    64'(tbl[k].ee));
      end

      // sustained 32 bits/cycle in and out at cnt=32
      apply(1, 0, 1, 32'h12345678, 0);
      for (int i = 0; i < 100; i++) begin
         w = 32'h12345678 ^ (32'(i) * 32'h01010101);
         apply(1, 0, 1, w, 32);
         chk("stream_odata",  64'(odata),  64'(w));
         chk("stream_oavail", 64'(oavail), 64'd32);
         chk("stream_iready", 64'(iready), 64'd1);
      end
      apply(1, 1, 0, 32'h0, 0);

      // random traffic, mostly legal consumes with occasional overrun/clear/reset
      for (int i = 0; i < 3000; i++) begin
         r  = int'($urandom_range(0, 99));
         rn = (r != 0);
         cl = (r == 1) || (r == 2);
         iv = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0)
            cs = 6'($urandom_range(0, 63));
         else if (mq.size() == 0)
            cs = 6'd0;
         else
            cs = 6'($urandom_range(0, (mq.size() > 32) ? 32 : mq.size()));
         apply(rn, cl, iv, $urandom, cs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bitstream_reader.md
# bitstream_reader

Variable-length bit unpacker for the decode path. It accepts a stream of 32-bit words packed LSB-first, where the first stream bit is bit 0 of the first word and word boundaries are transparent. It presents the next up-to-32 unread bits as a peek window, and lets a downstream field decoder consume 0..32 bits per cycle. It is the read-side counterpart of the codebase's variable-length bit packer. It also exposes the pad count to the next byte boundary, so a decoder can skip byte-alignment padding.

## Interface
- No parameters; word width fixed at 32, buffer depth fixed at 64 bits.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `clear` in 1: synchronous stream restart; same effect as reset on all state.
- `ivalid` in 1: input word valid.
- `iready` out 1: buffer can take a word this cycle.
- `idata` in 32: packed input word, LSB = earliest bit.
- `odata` out 32: peek window; bit 0 = next unread bit; bits at or above `oavail` are 0.
- `oavail` out 7: unread bits buffered, 0..64.
- `opad` out 3: bits to next byte boundary of the consumed position, `(-pos) mod 8`.
- `consume` in 6: bits to drop this cycle, 0..32.
- `err` out 1: sticky overrun flag.

## Operation
- State:
  - `buf[63:0]`: unread bits, LSB-aligned.
  - `cnt[6:0]`: same value as `oavail`.
  - `pos[2:0]`: total consumed bits mod 8.
  - `err`.
- Effective consume: `c = min(consume, cnt, 32)`.
  - If `consume > cnt` or `consume > 32`, set `err` and consume only `c`.
  - `err` stays set until reset or `clear`.
- Accept: `acc = ivalid & iready`, where `iready = (cnt <= 32)` and is derived only from registers.
- Next state:
  - `rem = cnt - c`.
  - `buf' = (buf >> c) | (acc ? idata << rem : 0)`, computed on 64 bits. Bits at or above `cnt'` are forced to 0.
  - `cnt' = rem + (acc ? 32 : 0)`. Because accepting requires `cnt <= 32`, we have `rem <= 32`, so `cnt' <= 64`.
  - `pos' = pos + c[2:0]`.
- Outputs:
  - `odata = buf[31:0]`.
  - `oavail = cnt`.
  - `opad = -pos`.
- `consume` and accept in the same cycle are legal and required.
- Consume is applied first; the new word lands directly above the remaining bits.
- `clear` or `!rst_n` has priority over everything:
  - `buf`, `cnt`, `pos`, `err` all go to 0.
  - A word presented with `ivalid & iready` in that cycle is discarded and counts as taken.
  - `consume` is ignored in that cycle.
- Byte alignment: the decoder drives `consume = opad` when `oavail >= opad`. No separate align input exists.

## Timing
- Reset values: `iready=1`, `odata=0`, `oavail=0`, `opad=0`, `err=0`.
- Latency: a word accepted in cycle N is visible in `odata`/`oavail` in cycle N+1.
- A consume in cycle N is reflected in cycle N+1.
- `odata`, `oavail`, `opad` and `err` are registers. `iready` is a compare on a register, so there is no combinational path from `consume` or `ivalid`.
- Throughput:
  - Sustains 32 bits/cycle in and out while `cnt` sits at 32.
  - At `cnt` in 33..64, input stalls until consumption brings `cnt` to 32 or below.
- Boundaries:
  - `cnt=0` with `consume>0`: nothing is consumed and `err` is set.
  - `cnt=64`: `iready=0`.
  - `consume=0`: hold.
  - `pos` wraps mod 8.

## Structure
- Shared package holds the constants `WORD_W=32`, `BUF_W=64`, `CNT_W=7` and `LEN_W=6`, which the packer also uses.
- The 64-bit right shift by `c` is a natural sub-module, `bit_shifter64`: a log-stage barrel, combinational, 6 stages.
- The rest of the block stays flat.

## Test plan
1. **Reset and fill.**
   - Release `rst_n`, push 0xDEADBEEF.
   - Next cycle: `oavail=32`, `odata=0xDEADBEEF`, `iready=1`.
2. **Straddling fields.**
   - Push 0x0000000F then 0xFFFFFFF0; consume 4, then 8.
   - Second read: `odata[7:0]=0x00`, `oavail=52`, `opad=4`.
3. **Simultaneous consume and accept at `cnt=32`.**
   - Consume 32 and push 0x12345678 each cycle for 100 cycles.
   - `iready` stays 1, `oavail` stays 32, and `odata` tracks each word one cycle later.
4. **Stall.**
   - Push three words with no consume.
   - `cnt` goes 32 → 64; the third word is held while `iready=0`.
   - Consume 32: `iready` rises next cycle and the third word lands above the remaining 32.
5. **Overrun.**
   - With `oavail=5`, drive `consume=9`.
   - Next cycle: `oavail=0`, `err=1`; `err` stays 1 until `clear`.
6. **Clear mid-stream.**
   - With `oavail=40` and `ivalid=1`, pulse `clear`.
   - Next cycle: all outputs at reset values, and the word presented during `clear` does not appear.
